// File: rtl/sreg_ctrl.sv
// sreg_ctrl: paces ce pulses and tracks per-stage validity for an external DEPTH-stage shift register
module sreg_ctrl #(
  parameter int DEPTH = 4,
  parameter int DW = 4,
  parameter int GAP = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DW-1:0]              s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DW-1:0]              m_data,
  input  logic                       flush,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       sreg_ce,
  output logic [DW-1:0]              sreg_din,
  input  logic [DW-1:0]              sreg_dout
);
  localparam int OW = $clog2(DEPTH+1);
  localparam int GW = GAP > 0 ? $clog2(GAP+1) : 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [DEPTH-1:0] vld, vld_n;
  logic [GW-1:0] gap_cnt;
  logic can_shift, push, bubble, pop;
  always_ff @(posedge clk) state <= rst ? RUN : state_n;
  always_comb state_n = state == RUN ? (flush ? FLUSH : RUN) : (vld_n == '0 ? RUN : FLUSH);
  always_comb begin
    can_shift = gap_cnt == '0 && (!vld[DEPTH-1] || m_ready);
    s_ready = !rst && state == RUN && can_shift && !flush;
    push = s_valid && s_ready;
    bubble = !rst && state == FLUSH && can_shift && vld != '0;
    sreg_ce = push || bubble;
    sreg_din = push ? s_data : '0;
    pop = vld[DEPTH-1] && m_ready;
    vld_n = sreg_ce ? (vld << 1) | DEPTH'(push) : pop ? vld & ~(DEPTH'(1) << (DEPTH-1)) : vld;
  end
  assign m_valid = vld[DEPTH-1];
  assign m_data = sreg_dout;
  assign busy = state != RUN || vld != '0;
  always_ff @(posedge clk)
    if (rst) begin
      vld <= '0;
      gap_cnt <= '0;
      occupancy <= '0;
    end else begin
      vld <= vld_n;
      gap_cnt <= sreg_ce ? GW'(GAP) : gap_cnt - GW'(gap_cnt != '0);
      occupancy <= OW'($countones(vld_n));
    end
endmodule

// File: tb/tb_sreg_ctrl.sv
// tb_sreg_ctrl: directed scenarios plus randomized traffic checked against a slot-array model of sreg_ctrl
module tb_sreg_ctrl;
  localparam int DEPTH = 4, DW = 4, GAP = 3;
  localparam int OW = $clog2(DEPTH+1);
  logic clk = 0, rst = 1, s_valid = 0, m_ready = 0, flush = 0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, m_valid, busy, sreg_ce;
  logic [DW-1:0] m_data, sreg_din, sreg_dout;
  logic [OW-1:0] occupancy;
  logic [DW-1:0] sreg [DEPTH];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    if (sreg_ce) begin
      for (int k = DEPTH - 1; k > 0; k--) sreg[k] <= sreg[k-1];
      sreg[0] <= sreg_din;
    end
  assign sreg_dout = sreg[DEPTH-1];

  sreg_ctrl #(.DEPTH(DEPTH), .DW(DW), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .flush(flush), .busy(busy),
    .occupancy(occupancy), .sreg_ce(sreg_ce), .sreg_din(sreg_din), .sreg_dout(sreg_dout)
  );

  // reference model: one slot per stage, head slot at DEPTH-1, plus an in-order scoreboard of accepted words
  bit mv [DEPTH];
  logic [DW-1:0] md [DEPTH];
  int mgap = 0;
  bit mfl = 0;
  logic [DW-1:0] sb [$];
  bit e_sready, e_push, e_ce, e_mvalid, e_busy;
  logic [DW-1:0] e_din;
  int e_occ;

  function automatic int nvalid();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) n += int'(mv[k]);
    return n;
  endfunction

  task automatic model_eval();
    bit room;
    room = mgap == 0 && (!mv[DEPTH-1] || m_ready);
    e_sready = !rst && !mfl && room && !flush;
    e_push = s_valid && e_sready;
    e_ce = e_push || (!rst && mfl && room && nvalid() > 0);
    e_din = e_push ? s_data : '0;
    e_mvalid = mv[DEPTH-1];
    e_occ = nvalid();
    e_busy = mfl || e_occ > 0;
  endtask

  task automatic tick();
    model_eval();
    if (rst) begin
      foreach (mv[k]) mv[k] = 0;
      mgap = 0;
      mfl = 0;
      sb.delete();
    end else begin
      if (e_mvalid && m_ready && sb.size() > 0) void'(sb.pop_front());
      if (e_push) sb.push_back(s_data);
      if (e_ce) begin
        for (int k = DEPTH - 1; k > 0; k--) begin mv[k] = mv[k-1]; md[k] = md[k-1]; end
        mv[0] = e_push;
        md[0] = e_din;
      end else if (e_mvalid && m_ready) mv[DEPTH-1] = 0;
      mgap = e_ce ? GAP : (mgap > 0 ? mgap - 1 : 0);
      mfl = mfl ? nvalid() > 0 : flush;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; s_valid = 0; flush = 0; m_ready = 0;
    tick();
    rst = 0;
  endtask

  task automatic fill(input int n, input int base);
    int cnt = 0, cyc = 0;
    s_valid = 1;
    while (cnt < n && cyc < 100) begin
      s_data = DW'(base + cnt);
      #1;
      if (sreg_ce) cnt++;
      tick();
      cyc++;
    end
    s_valid = 0;
    checks++;
    if (cnt != n) begin failures++; $display("FAIL fill_timeout got=%0d exp=%0d", cnt, n); end
  endtask

  task automatic test_reset();
    rst = 1; s_valid = 1; m_ready = 1; s_data = 4'h5;
    tick();
    #1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%0b exp=0", s_ready); end
    checks++; if (sreg_ce !== 1'b0) begin failures++; $display("FAIL rst_ce got=%0b exp=0", sreg_ce); end
    checks++; if (sreg_din !== '0) begin failures++; $display("FAIL rst_din got=%0h exp=0", sreg_din); end
    tick();
    rst = 0; s_valid = 0;
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%0b exp=0", m_valid); end
    checks++; if (occupancy !== '0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (sreg_ce !== 1'b0) begin failures++; $display("FAIL rst_ce_after got=%0b exp=0", sreg_ce); end
  endtask

  task automatic test_fill_stream();
    int w = 1, nxt = 1, cnt = 0, last = -1, cyc = 0;
    bit ce;
    do_reset();
    s_valid = 1; m_ready = 1;
    while ((cnt < 8 || nxt < 5) && cyc < 80) begin
      s_data = DW'(w);
      #1;
      ce = sreg_ce;
      if (ce) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != GAP + 1) begin failures++; $display("FAIL fill_spacing got=%0d exp=%0d", cyc - last, GAP + 1); end
        end
        checks++;
        if (sreg_din !== DW'(w)) begin failures++; $display("FAIL fill_din got=%0h exp=%0h", sreg_din, DW'(w)); end
        last = cyc;
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== DW'(nxt)) begin failures++; $display("FAIL fill_order got=%0h exp=%0h", m_data, DW'(nxt)); end
        nxt++;
      end
      tick();
      cyc++;
      if (ce) begin
        w++; cnt++;
        if (cnt == 4) begin
          checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL fill_m_valid got=%0b exp=1", m_valid); end
          checks++; if (m_data !== DW'(1)) begin failures++; $display("FAIL fill_head got=%0h exp=1", m_data); end
          checks++; if (occupancy !== OW'(4)) begin failures++; $display("FAIL fill_occ got=%0d exp=4", occupancy); end
        end
      end
    end
    s_valid = 0;
    checks++;
    if (cyc >= 80) begin failures++; $display("FAIL fill_timeout got=%0d exp=<80", cyc); end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready = 0;
    fill(4, 1);
    s_valid = 1; s_data = 4'h9;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready got=%0b exp=0", s_ready); end
      checks++; if (sreg_ce !== 1'b0) begin failures++; $display("FAIL bp_ce got=%0b exp=0", sreg_ce); end
      checks++; if (m_valid !== 1'b1 || m_data !== DW'(1)) begin failures++; $display("FAIL bp_head got=%0b/%0h exp=1/1", m_valid, m_data); end
      tick();
    end
    s_valid = 0;
  endtask

  task automatic test_flush();
    int got = 0, bub = 0, cyc = 0;
    do_reset();
    m_ready = 1;
    fill(3, 10);
    checks++; if (occupancy !== OW'(3)) begin failures++; $display("FAIL flush_occ_pre got=%0d exp=3", occupancy); end
    flush = 1;
    #1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL flush_s_ready got=%0b exp=0", s_ready); end
    tick();
    flush = 0;
    while (busy && cyc < 60) begin
      #1;
      if (sreg_ce) begin
        bub++;
        checks++; if (sreg_din !== '0) begin failures++; $display("FAIL flush_din got=%0h exp=0", sreg_din); end
      end
      if (m_valid && m_ready) begin
        checks++; if (m_data !== DW'(10 + got)) begin failures++; $display("FAIL flush_order got=%0h exp=%0h", m_data, DW'(10 + got)); end
        got++;
      end
      tick();
      cyc++;
    end
    checks++; if (got != 3) begin failures++; $display("FAIL flush_words got=%0d exp=3", got); end
    checks++; if (bub != 3) begin failures++; $display("FAIL flush_bubbles got=%0d exp=3", bub); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%0b exp=0", busy); end
    checks++; if (occupancy !== '0 || m_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%0d/%0b exp=0/0", occupancy, m_valid); end
  endtask

  task automatic test_flush_priority();
    do_reset();
    s_valid = 1; flush = 1; m_ready = 1; s_data = 4'h7;
    #1;
    checks++; if (s_ready !== 1'b0 || sreg_ce !== 1'b0) begin failures++; $display("FAIL prio_push got=%0b/%0b exp=0/0", s_ready, sreg_ce); end
    tick();
    flush = 0; s_valid = 0;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prio_busy got=%0b exp=1", busy); end
    checks++; if (sreg_ce !== 1'b0) begin failures++; $display("FAIL prio_ce got=%0b exp=0", sreg_ce); end
    tick();
    s_valid = 1;
    #1;
    checks++; if (busy !== 1'b0 || occupancy !== '0) begin failures++; $display("FAIL prio_idle got=%0b/%0d exp=0/0", busy, occupancy); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL prio_resume got=%0b exp=1", s_ready); end
    tick();
    s_valid = 0;
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    m_ready = 0;
    fill(2, 3);
    flush = 1;
    tick();
    flush = 0;
    #1;
    checks++; if (busy !== 1'b1 || occupancy !== OW'(2)) begin failures++; $display("FAIL rmf_pre got=%0b/%0d exp=1/2", busy, occupancy); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++; if (m_valid !== 1'b0 || occupancy !== '0) begin failures++; $display("FAIL rmf_clear got=%0b/%0d exp=0/0", m_valid, occupancy); end
    checks++; if (busy !== 1'b0 || sreg_ce !== 1'b0) begin failures++; $display("FAIL rmf_idle got=%0b/%0b exp=0/0", busy, sreg_ce); end
    s_valid = 1; s_data = 4'h5;
    #1;
    checks++; if (s_ready !== 1'b1 || sreg_ce !== 1'b1) begin failures++; $display("FAIL rmf_push got=%0b/%0b exp=1/1", s_ready, sreg_ce); end
    tick();
    s_valid = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(0, 299) == 0;
      s_valid = $urandom_range(0, 3) != 0;
      s_data = DW'($urandom);
      m_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 39) == 0;
      #1;
      model_eval();
      checks++; if (s_ready !== e_sready) begin failures++; $display("FAIL rnd_s_ready cyc=%0d got=%0b exp=%0b", i, s_ready, e_sready); end
      checks++; if (sreg_ce !== e_ce) begin failures++; $display("FAIL rnd_ce cyc=%0d got=%0b exp=%0b", i, sreg_ce, e_ce); end
      checks++; if (sreg_din !== e_din) begin failures++; $display("FAIL rnd_din cyc=%0d got=%0h exp=%0h", i, sreg_din, e_din); end
      checks++; if (m_valid !== e_mvalid) begin failures++; $display("FAIL rnd_m_valid cyc=%0d got=%0b exp=%0b", i, m_valid, e_mvalid); end
      checks++; if (occupancy !== OW'(e_occ)) begin failures++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", i, occupancy, e_occ); end
      checks++; if (busy !== e_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", i, busy, e_busy); end
      if (e_mvalid) begin
        checks++; if (m_data !== md[DEPTH-1]) begin failures++; $display("FAIL rnd_m_data cyc=%0d got=%0h exp=%0h", i, m_data, md[DEPTH-1]); end
        if (m_ready) begin
          checks++;
          if (sb.size() == 0) begin failures++; $display("FAIL rnd_order cyc=%0d got=%0h exp=<none>", i, m_data); end
          else if (m_data !== sb[0]) begin failures++; $display("FAIL rnd_order cyc=%0d got=%0h exp=%0h", i, m_data, sb[0]); end
        end
      end
      tick();
    end
    rst = 0; s_valid = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_fill_stream();
    test_backpressure();
    test_flush();
    test_flush_priority();
    test_reset_mid_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
